// File: rtl/cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_ctrl
//
// Purpose:
//   Multi-cycle WIDTH-bit add / subtract / accumulate unit built around one
//   shared 4-bit carry-lookahead adder. Operands are latched on a start
//   strobe, then processed one nibble per clock, LSB nibble first. The
//   inter-nibble carry lives in a register between steps. The result is
//   published together with a one-cycle done pulse.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request, only looked at while idle
//   op     in   2'b00 add, 2'b01 sub, 2'b10 accumulate, 2'b11 add
//   a      in   operand A (not used for accumulate)
//   b      in   operand B
//   cin    in   carry in for add/accumulate (sub always seeds 1)
//   busy   out  high while nibbles are being processed
//   done   out  one-cycle pulse in the cycle after sum/cout/ovf update
//   sum    out  result register
//   cout   out  carry out of the MSB nibble (sub: 1 = no borrow)
//   ovf    out  two's-complement overflow of the last operation
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder: all carries are derived directly from the
// generate/propagate terms instead of rippling through the bit positions.
module carry_lookahead_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q,   opa_d;
  logic [WIDTH-1:0]  opb_q,   opb_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]  work_q,  work_d;
  logic [WIDTH-1:0]  sum_q,   sum_d;
  logic              cout_q,  cout_d;
  logic              ovf_q,   ovf_d;

  // Nibble views of the latched operands, selected by the step index.
  logic [3:0] opa_nib [N];
  logic [3:0] opb_nib [N];
  logic [3:0] cla_a;
  logic [3:0] cla_b;
  logic [3:0] cla_s;
  logic       cla_cout;
  logic       run_step;

  assign run_step = (state_q == S_RUN);

  for (genvar gi = 0; gi < N; gi++) begin : g_nib
    assign opa_nib[gi] = opa_q[gi*4 +: 4];
    assign opb_nib[gi] = opb_q[gi*4 +: 4];
    // The work register only takes the adder output in its own nibble
    // slot; every other slot holds.
    assign work_d[gi*4 +: 4] = (run_step && (idx_q == IDXW'(gi)))
                               ? cla_s : work_q[gi*4 +: 4];
  end

  assign cla_a = opa_nib[idx_q];
  assign cla_b = opb_nib[idx_q];

  carry_lookahead_adder u_cla (
    .a_i    (cla_a),
    .b_i    (cla_b),
    .cin_i  (carry_q),
    .s_o    (cla_s),
    .cout_o (cla_cout)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          // Subtraction is a + ~b + 1; accumulate feeds back the current sum.
          opa_d   = (op == 2'b10) ? sum_q : a;
          opb_d   = (op == 2'b01) ? ~b : b;
          carry_d = (op == 2'b01) ? 1'b1 : cin;
        end
      end

      S_RUN: begin
        carry_d = cla_cout;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          // work_d already holds the final nibble, so publish it directly.
          sum_d   = work_d;
          cout_d  = cla_cout;
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (cla_s[3] != opa_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_ctrl
//
// Purpose:
//   Self-checking bench for cla_seq_ctrl (WIDTH=16). Directed vectors from a
//   table, hand-written protocol sequences, and random operations compared
//   against an arithmetic reference model of add/sub/accumulate.
// ---------------------------------------------------------------------------
module tb_cla_seq_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  // Reference model state: the result the DUT should currently hold.
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;

  cla_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Whole-word arithmetic: opA + opB + seed, with the sign rule for ovf.
  task automatic model_op(input logic [1:0] mop, input logic [W-1:0] ma,
                          input logic [W-1:0] mb, input logic mcin);
    logic [W-1:0] opa, opb;
    logic [W:0]   full;
    logic         seed;
    opa  = (mop == 2'b10) ? m_sum : ma;
    opb  = (mop == 2'b01) ? ~mb : mb;
    seed = (mop == 2'b01) ? 1'b1 : mcin;
    full = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, seed};
    m_sum  = full[W-1:0];
    m_cout = full[W];
    m_ovf  = (opa[W-1] == opb[W-1]) && (full[W-1] != opa[W-1]);
  endtask

  // Issue one operation from IDLE, check busy length, done pulse and
  // results against the model. Returns in IDLE with inputs scrambled.
  task automatic run_op(input string tag, input logic [1:0] vop,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin);
    int busy_cnt = 0;
    int guard    = 0;
    bit overlap  = 0;
    model_op(vop, va, vb, vcin);
    op = vop; a = va; b = vb; cin = vcin; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    op = 2'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    while (!done && guard < 20) begin
      if (busy) busy_cnt++;
      tick();
      guard++;
    end
    if (busy && done) overlap = 1;
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " busy_cycles"}, busy_cnt, N);
    check({tag, " no_overlap"}, 32'(overlap), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(m_sum));
    check({tag, " cout"}, 32'(cout), 32'(m_cout));
    check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    tick();                       // E_{N+1}
    check({tag, " done_fell"}, 32'(done), 32'd0);
    check({tag, " sum_held"}, 32'(sum), 32'(m_sum));
  endtask

  initial begin
    int dcnt;
    int guard;
    logic [W-1:0] held;

    rst = 1'b1; start = 1'b1; op = 2'b00; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;

    // Reset with start held high for two cycles.
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("reset%0d busy/done/cout/ovf", i),
            {28'd0, busy, done, cout, ovf}, 32'd0);
      check($sformatf("reset%0d sum", i), 32'(sum), 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    tick();

    // Directed table.
    vecs[0] = '{2'b00, 16'h1234, 16'h0FCF, 1'b0, 16'h2203, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 16'h1111, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("tbl%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("tbl%0d sum_const", i), 32'(sum), 32'(vecs[i].e_sum));
      check($sformatf("tbl%0d cout_const", i), 32'(cout), 32'(vecs[i].e_cout));
      check($sformatf("tbl%0d ovf_const", i), 32'(ovf), 32'(vecs[i].e_ovf));
    end
    run_op("acc2", 2'b10, 16'hABCD, 16'h0003, 1'b1);
    check("acc2 sum_const", 32'(sum), 32'h0004);

    // Start pulse during RUN is ignored: one done, correct result.
    model_op(2'b00, 16'h0102, 16'h0304, 1'b0);
    op = 2'b00; a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("start_in_run done_count", dcnt, 1);
    check("start_in_run sum", 32'(sum), 32'(m_sum));

    // Start pulse during the done cycle is ignored.
    op = 2'b00; a = 16'h0010; b = 16'h0020; cin = 1'b1; start = 1'b1;
    model_op(2'b00, 16'h0010, 16'h0020, 1'b1);
    tick();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 20) begin tick(); guard++; end
    check("start_in_done first_done", 32'(done), 32'd1);
    held = sum;
    start = 1'b1; a = 16'h5555; b = 16'h5555;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dcnt++;
      tick();
    end
    check("start_in_done no_activity", dcnt, 0);
    check("start_in_done sum_held", 32'(sum), 32'(held));
    check("start_in_done sum_model", 32'(sum), 32'(m_sum));

    // Reset asserted in the second RUN cycle.
    op = 2'b00; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick();                       // E1: now in 2nd RUN cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy/done/cout/ovf", {28'd0, busy, done, cout, ovf}, 32'd0);
    check("midrst sum", 32'(sum), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("midrst no_done", dcnt, 0);
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;

    // Back-to-back: start held high through the done cycle is taken at the
    // first idle edge.
    op = 2'b00; a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    tick();
    guard = 0;
    while (!done && guard < 20) begin tick(); guard++; end
    check("b2b first_done", 32'(done), 32'd1);
    guard = 0;
    while (!busy && guard < 3) begin tick(); guard++; end
    start = 1'b0;
    check("b2b second_accepted", 32'(busy), 32'd1);
    guard = 0;
    while (!done && guard < 20) begin tick(); guard++; end
    check("b2b second_sum", 32'(sum), 32'h0003);
    tick();
    m_sum = 16'h0003; m_cout = 1'b0; m_ovf = 1'b0;

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom), W'($urandom), W'($urandom),
             1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

  // Global timeout so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
